// File: rtl/comparador_serial.sv
// Serial magnitude comparator: compares two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, unsigned or two's complement, stopping at the first
// differing chunk and reporting through a start/busy/done handshake.
module comparador_serial #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             AmaiorB,
   output logic             AmenorB,
   output logic             AigualB
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
         $error("comparador_serial: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] msb_flip;
   logic [CHUNK-1:0] top_a;
   logic [CHUNK-1:0] top_b;
   logic [IDX_W-1:0] idx;
   logic             accept;
   logic             differ;
   logic             last;

   // In signed mode the MSB is inverted (offset binary) so that a plain
   // unsigned chunk compare yields the two's-complement order.
   assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
   assign top_a    = sh_a[WIDTH-1 -: CHUNK];
   assign top_b    = sh_b[WIDTH-1 -: CHUNK];
   assign accept   = (state == IDLE) && start;
   assign differ   = (top_a != top_b);
   assign last     = (idx == IDX_W'(N - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: leave RUN on the first differing chunk or after the last one
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (differ || last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: busy is a pure decode of the state
   always_comb begin
      busy = (state == RUN);
   end

   // Operand shift registers: load on accept, shift one chunk per RUN cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         sh_a <= A ^ msb_flip;
         sh_b <= B ^ msb_flip;
      end else if (state == RUN) begin
         sh_a <= sh_a << CHUNK;
         sh_b <= sh_b << CHUNK;
      end
   end

   // Chunk index, done pulse and result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         done    <= 1'b0;
         AmaiorB <= 1'b0;
         AmenorB <= 1'b0;
         AigualB <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            idx     <= '0;
            AmaiorB <= 1'b0;
            AmenorB <= 1'b0;
            AigualB <= 1'b0;
         end else if (state == RUN) begin
            if (differ) begin
               AmaiorB <= (top_a > top_b);
               AmenorB <= (top_a < top_b);
               done    <= 1'b1;
            end else if (last) begin
               AigualB <= 1'b1;
               done    <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_comparador_serial.sv
// Bench for comparador_serial: three instances (CHUNK=1,4,2, WIDTH=8) share
// the stimulus; a behavioural model is compared every cycle and directed
// vectors pin latencies and flags with hand-computed values.
module tb_comparador_serial;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sm;
   logic [7:0] a_in;
   logic [7:0] b_in;

   logic [2:0] d_busy, d_done, d_gt, d_lt, d_eq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   comparador_serial #(.WIDTH(8), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .A(a_in), .B(b_in),
      .busy(d_busy[0]), .done(d_done[0]), .AmaiorB(d_gt[0]), .AmenorB(d_lt[0]), .AigualB(d_eq[0]));
   comparador_serial #(.WIDTH(8), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .A(a_in), .B(b_in),
      .busy(d_busy[1]), .done(d_done[1]), .AmaiorB(d_gt[1]), .AmenorB(d_lt[1]), .AigualB(d_eq[1]));
   comparador_serial #(.WIDTH(8), .CHUNK(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sm), .A(a_in), .B(b_in),
      .busy(d_busy[2]), .done(d_done[2]), .AmaiorB(d_gt[2]), .AmenorB(d_lt[2]), .AigualB(d_eq[2]));

   function automatic logic [2:0] dut_flags(int i);
      return {d_gt[i], d_lt[i], d_eq[i]};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Latency = 1-based index of the first differing chunk of A^B from the MSB
   // (the signed MSB inversion leaves A^B unchanged), or N when equal.
   function automatic int first_diff(logic [7:0] x, int c);
      logic [7:0] t;
      for (int j = 0; j < 8 / c; j++) begin
         t = x << (j * c);
         if ((t >> (8 - c)) != 8'd0) return j + 1;
      end
      return 8 / c;
   endfunction

   // Flags {gt, lt, eq} from plain arithmetic comparison
   function automatic logic [2:0] order(logic [7:0] a, logic [7:0] b, logic s);
      if (s) begin
         if ($signed(a) > $signed(b)) return 3'b100;
         if ($signed(a) < $signed(b)) return 3'b010;
      end else begin
         if (a > b) return 3'b100;
         if (a < b) return 3'b010;
      end
      return 3'b001;
   endfunction

   localparam int CH [3] = '{1, 4, 2};

   logic [2:0] m_busy, m_done;
   int         m_cnt  [3];
   logic [2:0] m_flag [3];
   logic [2:0] m_res  [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= '0;
         m_done <= '0;
         for (int i = 0; i < 3; i++) begin
            m_cnt[i]  <= 0;
            m_flag[i] <= '0;
            m_res[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            m_done[i] <= 1'b0;
            if (!m_busy[i]) begin
               if (start) begin
                  m_busy[i] <= 1'b1;
                  m_flag[i] <= '0;
                  m_cnt[i]  <= first_diff(a_in ^ b_in, CH[i]);
                  m_res[i]  <= order(a_in, b_in, sm);
               end
            end else if (m_cnt[i] == 1) begin
               m_busy[i] <= 1'b0;
               m_done[i] <= 1'b1;
               m_flag[i] <= m_res[i];
            end else begin
               m_cnt[i] <= m_cnt[i] - 1;
            end
         end
      end
   end

   // Every-cycle comparison of all instances against the model
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("busy_c%0d", CH[i]), 32'(d_busy[i]), rst_n ? 32'(m_busy[i]) : 32'd0);
         chk($sformatf("done_c%0d", CH[i]), 32'(d_done[i]), rst_n ? 32'(m_done[i]) : 32'd0);
         chk($sformatf("flags_c%0d", CH[i]), 32'(dut_flags(i)), rst_n ? 32'(m_flag[i]) : 32'd0);
      end
   end

   // ---------------- directed stimulus ----------------
   int         lat_r [3];
   logic [2:0] fl_r  [3];

   // Count edges after the accepting edge until each instance pulses done
   task automatic measure(input bit vary);
      for (int i = 0; i < 3; i++) begin
         lat_r[i] = 0;
         fl_r[i]  = '0;
      end
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (vary && e == 1) a_in = 8'h00;
         if (vary && e == 2) begin
            a_in  = 8'hFF;
            start = 1'b0;
         end
         for (int i = 0; i < 3; i++)
            if (d_done[i] && lat_r[i] == 0) begin
               lat_r[i] = e;
               fl_r[i]  = dut_flags(i);
            end
         if (lat_r[0] != 0 && lat_r[1] != 0 && lat_r[2] != 0 && (!vary || e >= 2)) break;
      end
      start = 1'b0;
   endtask

   // Issue a compare now (inputs change #1 after an edge) and check literals
   task automatic do_cmp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input bit vary,
                         input int l1, input int l4, input int l2, input logic [2:0] f);
      int exp_lat [3];
      exp_lat = '{l1, l4, l2};
      a_in  = a;
      b_in  = b;
      sm    = s;
      start = 1'b1;
      @(posedge clk); #1;
      if (!vary) start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_busy_c%0d", name, CH[i]), 32'(d_busy[i]), 32'd1);
         chk($sformatf("%s_flags0_c%0d", name, CH[i]), 32'(dut_flags(i)), 32'd0);
      end
      measure(vary);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_lat_c%0d", name, CH[i]), 32'(lat_r[i]), 32'(exp_lat[i]));
         chk($sformatf("%s_res_c%0d", name, CH[i]), 32'(fl_r[i]), 32'(f));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      sm    = 1'b0;
      a_in  = 8'h00;
      b_in  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_busy_c%0d", CH[i]), 32'(d_busy[i]), 32'd0);
         chk($sformatf("reset_flags_c%0d", CH[i]), 32'(dut_flags(i)), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      //                       A      B     sm  vary  c1 c4 c2  {gt,lt,eq}
      do_cmp("eq_a5",       8'hA5, 8'hA5, 1'b0, 1'b0, 8, 2, 4, 3'b001);
      do_cmp("u_80_7f",     8'h80, 8'h7F, 1'b0, 1'b0, 1, 1, 1, 3'b100);
      do_cmp("s_80_7f",     8'h80, 8'h7F, 1'b1, 1'b0, 1, 1, 1, 3'b010);
      do_cmp("u_3c_3d",     8'h3C, 8'h3D, 1'b0, 1'b0, 8, 2, 4, 3'b010);
      do_cmp("u_4c_3d",     8'h4C, 8'h3D, 1'b0, 1'b0, 2, 1, 1, 3'b100);
      do_cmp("s_ff_fe",     8'hFF, 8'hFE, 1'b1, 1'b0, 8, 2, 4, 3'b100);
      do_cmp("s_00_ff",     8'h00, 8'hFF, 1'b1, 1'b0, 1, 1, 1, 3'b100);
      do_cmp("u_12_34",     8'h12, 8'h34, 1'b0, 1'b0, 3, 1, 2, 3'b010);
      // start held three cycles while A changes: only the first A counts
      do_cmp("hold_start",  8'hA5, 8'hA5, 1'b0, 1'b1, 8, 2, 4, 3'b001);
      // issued in the done cycle of the previous compare
      do_cmp("back2back",   8'h80, 8'h7F, 1'b0, 1'b0, 1, 1, 1, 3'b100);

      // Asynchronous reset three edges into an equal compare
      a_in  = 8'hA5;
      b_in  = 8'hA5;
      sm    = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("abort_busy_c%0d", CH[i]), 32'(d_busy[i]), 32'd0);
         chk($sformatf("abort_done_c%0d", CH[i]), 32'(d_done[i]), 32'd0);
         chk($sformatf("abort_flags_c%0d", CH[i]), 32'(dut_flags(i)), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         chk("abort_no_done", 32'(d_done), 32'd0);
      end
      do_cmp("after_rst",   8'h12, 8'h34, 1'b0, 1'b0, 3, 1, 2, 3'b010);

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
